// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers and sizing for the async FIFO controllers
package fifo_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Helpers work on 32-bit vectors; callers zero-extend and truncate to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width two-flop synchronizer with async active-low reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side pointer, strobe and pessimistic status flags
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  WrEn_in,
  input  logic [ADDR_WIDTH:0]   RdPtrGray_in,
  output logic [ADDR_WIDTH-1:0] WrAddr_out,
  output logic                  WrStrobe_out,
  output logic [ADDR_WIDTH:0]   WrPtrGray_out,
  output logic                  Full_out,
  output logic                  AlmostFull_out,
  output logic [ADDR_WIDTH:0]   Level_out,
  output logic                  WrErr_out
);

  localparam int A     = ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [A:0] wbin_d, wbin_q;
  logic [A:0] wgray_d, wgray_q;
  logic [A:0] level_d, level_q;
  logic       full_d, full_q;
  logic       afull_d, afull_q;
  logic       wrerr_d, wrerr_q;
  logic [A:0] rq2;
  logic [A:0] rbin_s;
  logic [A:0] free_d;
  logic       wr_strobe;

  sync_2ff #(.WIDTH(PTR_W)) u_rptr_sync (
    .clk   (Clk),
    .rst_n (Rst_n),
    .d_in  (RdPtrGray_in),
    .q_out (rq2)
  );

  always_comb begin
    // No RAM write may escape while reset is held, even with WrEn_in high.
    wr_strobe = WrEn_in & ~full_q & Rst_n;
    wbin_d    = wr_strobe ? wbin_q + 1'b1 : wbin_q;
    wgray_d   = PTR_W'(bin2gray(32'(wbin_d)));
    rbin_s    = PTR_W'(gray2bin(32'(rq2)));
    level_d   = wbin_d - rbin_s;
    free_d    = PTR_W'(DEPTH) - level_d;
    full_d    = (wgray_d == {~rq2[A:A-1], rq2[A-2:0]});
    afull_d   = (free_d <= PTR_W'(AF_MARGIN));
    wrerr_d   = WrEn_in & full_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      wrerr_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      wrerr_q <= wrerr_d;
    end
  end

  assign WrAddr_out     = wbin_q[A-1:0];
  assign WrStrobe_out   = wr_strobe;
  assign WrPtrGray_out  = wgray_q;
  assign Full_out       = full_q;
  assign AlmostFull_out = afull_q;
  assign Level_out      = level_q;
  assign WrErr_out      = wrerr_q;

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side control for the async FIFO, in the write clock domain. It accepts write requests and generates the write address and strobe for the dual-port RAM. It publishes the write pointer in Gray code for the read domain and brings the read domain's Gray pointer in through a 2-flop synchronizer. From that synchronized pointer it derives the full, almost-full and fill-level status.

## Interface
- ADDR_WIDTH, 4: RAM address bits; DEPTH = 2**ADDR_WIDTH; minimum 2.
- AF_MARGIN, 2: AlmostFull_out asserts when free entries ≤ AF_MARGIN; range 1..DEPTH-1.

- Clk  input  1  write-domain clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- WrEn_in  input  1  write request, sampled each rising edge.
- RdPtrGray_in  input  ADDR_WIDTH+1  read pointer (Gray) from read domain, asynchronous to Clk.
- WrAddr_out  output  ADDR_WIDTH  binary RAM write address.
- WrStrobe_out  output  1  RAM write enable; combinational, WrEn_in & ~Full_out.
- WrPtrGray_out  output  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer.
- Full_out  output  1  registered full flag.
- AlmostFull_out  output  1  registered almost-full flag.
- Level_out  output  ADDR_WIDTH+1  registered fill level, 0..DEPTH, pessimistic.
- WrErr_out  output  1  one-cycle pulse, write attempted while full.

## Operation
- State: binary pointer wbin and Gray pointer wgray, each ADDR_WIDTH+1 bits; MSB is the wrap bit.
- Synchronizer registers: rq1, rq2.
- Accept: WrStrobe_out = WrEn_in & ~Full_out.
  - On accept: wbin_next = wbin+1 mod 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next>>1).
  - Otherwise the pointers hold.
- WrAddr_out = wbin[ADDR_WIDTH-1:0]. The RAM writes the entry at the current address on the accepting edge.
- WrPtrGray_out = wgray. Only one bit changes per increment, so it is safe to cross domains.
- Synchronizer: rq1 <= RdPtrGray_in; rq2 <= rq1. Only rq2 is used downstream.
- rbin_s is the Gray-to-binary conversion of rq2: rbin_s[i] = XOR of rq2[ADDR_WIDTH:i].
- Full: Full_out <= (wgray_next == {~rq2[A:A-1], rq2[A-2:0]}), with A = ADDR_WIDTH.
- Level: Level_out <= (wbin_next − rbin_s) mod 2**(A+1). The result never exceeds DEPTH.
- AlmostFull_out <= (DEPTH − level_next) ≤ AF_MARGIN.
- Overflow: WrEn_in & Full_out drops the write (pointers and RAM unchanged) and sets WrErr_out <= 1 for one cycle.
- Status is pessimistic: the synchronized read pointer lags the read domain. Full may stay asserted after reads; it is never deasserted early.

## Timing
- Reset (Rst_n low, asynchronous):
  - wbin, wgray, rq1, rq2, WrAddr_out, WrPtrGray_out = 0.
  - Full_out = 0, AlmostFull_out = 0, Level_out = 0, WrErr_out = 0.
- Release of reset is synchronized externally. The block takes no action until the first rising edge after Rst_n is high.
- Write latency:
  - An accepted write at edge N updates WrPtrGray_out, WrAddr_out, Level_out and the flags, all visible after edge N.
  - The write that fills the last entry raises Full_out on that same edge. A write in cycle N+1 is then refused.
- Read-side visibility: a change on RdPtrGray_in reaches rq2 after 2 edges. Flags and Level update on the 3rd edge.
- Wrap-around:
  - wbin rolls from 2**(A+1)−1 to 0 with no glitch in the flags.
  - Level is computed modulo 2**(A+1), so it stays correct across the wrap.
- Simultaneous write and read-pointer change: both are applied in the same next-state computation. Full is evaluated against the post-write pointer and the current rq2.
- Reset mid-operation: all state clears immediately and pending writes are lost. The read domain must be reset concurrently (system requirement, not checked here).

## Structure
- Shared package fifo_pkg:
  - function gray2bin;
  - function bin2gray;
  - localparam computation of DEPTH from ADDR_WIDTH.
  - The read-side controller reuses all of these.
- Sub-module sync_2ff: parameterized-width 2-flop synchronizer with async active-low reset. It is instantiated once here and reused by the read-side controller.
- Pointer and flag logic stay flat in fifo_wr_ctrl. No FSM beyond the pointer registers.

## Test plan
- Reset and idle:
  - Stimulus: assert Rst_n low mid-cycle with WrEn_in=1, RdPtrGray_in=0.
  - Required: all outputs are 0 immediately, and remain 0 until the first edge after release.
- Fill to full (ADDR_WIDTH=4, RdPtrGray_in held 0):
  - Stimulus: 16 consecutive writes.
  - Required: WrAddr_out steps 0..15, WrPtrGray_out follows the Gray sequence 0,1,3,2,6,…
  - Required: AlmostFull_out rises after write 14. Full_out and Level_out=16 appear after write 16.
- Overflow:
  - Stimulus: a 17th write while full.
  - Required: WrStrobe_out=0, WrErr_out pulses one cycle, pointers unchanged.
- Drain release:
  - Stimulus: from full, drive RdPtrGray_in to Gray(4)=6.
  - Required: Full_out drops exactly 3 edges later, with Level_out=12 and AlmostFull_out=0.
- Wrap-around:
  - Stimulus: stream 40 writes while RdPtrGray_in tracks wbin−3 (in Gray).
  - Required: Full_out never asserts and Level_out settles at 5, including across wbin 31→0.
- Gray property: a random-traffic assertion that WrPtrGray_out changes by exactly one bit or not at all on every edge.
